// File: rtl/mul_issue_ctrl_pkg.sv
// Shared types and defaults for the multiplier issue controller.
package mul_pkg;

    localparam int unsigned MUL_SIZE  = 32;
    localparam int unsigned MUL_DEPTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic [MUL_SIZE-1:0] a;
        logic [MUL_SIZE-1:0] b;
    } op_pair_t;

endpackage

// File: rtl/mul_issue_ctrl_if.sv
// Producer, core and consumer handshake signals of the issue controller.
// The controller connects through the slave modport.
interface mul_issue_ctrl_if #(
    parameter int unsigned SIZE = mul_pkg::MUL_SIZE
);
    logic            in_valid;
    logic            in_ready;
    logic [SIZE-1:0] in_a;
    logic [SIZE-1:0] in_b;
    logic            core_start;
    logic [SIZE-1:0] core_a;
    logic [SIZE-1:0] core_b;
    logic            core_done;
    logic [SIZE-1:0] core_result;
    logic            out_valid;
    logic            out_ready;
    logic [SIZE-1:0] out_result;

    modport master (
        output in_valid, in_a, in_b, core_done, core_result, out_ready,
        input  in_ready, core_start, core_a, core_b, out_valid, out_result
    );

    modport slave (
        input  in_valid, in_a, in_b, core_done, core_result, out_ready,
        output in_ready, core_start, core_a, core_b, out_valid, out_result
    );
endinterface

// File: rtl/mul_issue_ctrl_op_fifo.sv
// Synchronous operand FIFO, combinational read of the head entry.
// DEPTH must be a power of 2 so the pointers wrap naturally.
module op_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [WIDTH-1:0]       din,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == (AW+1)'(DEPTH));
    assign empty  = (r_count == '0);
    assign count  = r_count;
    assign dout   = r_mem[r_rd_ptr];
    assign w_push = push && !full;
    assign w_pop  = pop && !empty;

    // Storage array, not reset
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    // Pointers and occupancy
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: rtl/mul_issue_ctrl.sv
// Issue controller for the repeated-addition multiplier core: buffers
// operand pairs, issues one at a time, holds the product until accepted.
// Optional macro SWAP_SMALLER_EN: issue the smaller operand as core_b.
module mul_issue_ctrl
    import mul_pkg::*;
#(
    parameter int unsigned SIZE  = MUL_SIZE,
    parameter int unsigned DEPTH = MUL_DEPTH
) (
    input logic            clk,
    input logic            rst,
    mul_issue_ctrl_if.slave bus
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] b;
    } pair_t;

    state_t          r_state;
    state_t          w_state_nxt;
    pair_t           w_push_pair;
    pair_t           w_pop_pair;
    logic            w_push;
    logic            w_pop;
    logic            w_full;
    logic            w_empty;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_count_nxt;
    logic            r_in_ready;
    logic            r_core_start;
    logic [SIZE-1:0] r_core_a;
    logic [SIZE-1:0] r_core_b;
    logic            r_out_valid;
    logic [SIZE-1:0] r_out_result;
    logic [SIZE-1:0] w_issue_a;
    logic [SIZE-1:0] w_issue_b;

    assign w_push      = bus.in_valid && r_in_ready && !w_full;
    assign w_push_pair = {bus.in_a, bus.in_b};

    op_fifo #(
        .WIDTH (2 * SIZE),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_push_pair),
        .dout  (w_pop_pair),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // Occupancy after this cycle, so in_ready can be registered
    always_comb begin
        w_count_nxt = w_count;
        if (w_push && !w_pop) begin
            w_count_nxt = w_count + 1'b1;
        end else if (!w_push && w_pop) begin
            w_count_nxt = w_count - 1'b1;
        end
    end

    // Next state and FIFO pop; pops only from IDLE
    always_comb begin
        w_state_nxt = r_state;
        w_pop       = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_empty) begin
                    w_pop       = 1'b1;
                    w_state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (bus.core_done) begin
                    w_state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

`ifdef SWAP_SMALLER_EN
    // Put the smaller operand on core_b to shorten the core's iteration
    always_comb begin
        w_issue_a = w_pop_pair.a;
        w_issue_b = w_pop_pair.b;
        if (w_pop_pair.a < w_pop_pair.b) begin
            w_issue_a = w_pop_pair.b;
            w_issue_b = w_pop_pair.a;
        end
    end
`else
    assign w_issue_a = w_pop_pair.a;
    assign w_issue_b = w_pop_pair.b;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Handshake and operand/result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_ready   <= 1'b0;
            r_core_start <= 1'b0;
            r_core_a     <= '0;
            r_core_b     <= '0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
        end else begin
            r_in_ready   <= (w_count_nxt != CW'(DEPTH));
            r_core_start <= w_pop;
            if (w_pop) begin
                r_core_a <= w_issue_a;
                r_core_b <= w_issue_b;
            end
            if (r_state == BUSY && bus.core_done) begin
                r_out_valid  <= 1'b1;
                r_out_result <= bus.core_result;
            end else if (r_state == HOLD && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.core_start = r_core_start;
    assign bus.core_a     = r_core_a;
    assign bus.core_b     = r_core_b;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
endmodule
